// File: rtl/npuarc_to_pkg.sv
// Shared constants and state encoding for the npuarc timeout-monitor initiator controller.
package npuarc_to_pkg;

  localparam int OST_WIDTH_DEF     = 4;
  localparam int ERR_CNT_WIDTH_DEF = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ARMED = 3'd1;
  localparam state_t ST_END   = 3'd2;
  localparam state_t ST_ABORT = 3'd3;
  localparam state_t ST_CLEAR = 3'd4;

endpackage

// File: rtl/npuarc_to_ost_cnt.sv
// Outstanding-request counter: one increment and two decrement sources, floored at zero.
module npuarc_to_ost_cnt
  import npuarc_to_pkg::*;
#(
  parameter int WIDTH = OST_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic             clk_en,
  input  logic             inc,
  input  logic             dec_a,
  input  logic             dec_b,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] cnt_nxt,
  output logic             full
);

  logic [WIDTH+1:0] sum;

  // Two guard bits: the top one flags a negative result, the next an overflow.
  always_comb begin
    sum = {2'b00, cnt}
        + {{(WIDTH+1){1'b0}}, inc}
        - {{(WIDTH+1){1'b0}}, dec_a}
        - {{(WIDTH+1){1'b0}}, dec_b};
    if (sum[WIDTH+1])
      cnt_nxt = '0;
    else if (sum[WIDTH])
      cnt_nxt = '1;
    else
      cnt_nxt = sum[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a)
      cnt <= '0;
    else if (clk_en)
      cnt <= cnt_nxt;
  end

  assign full = &cnt;

endmodule

// File: rtl/npuarc_to_ctrl.sv
// Initiator-side controller for the npuarc timeout monitor: drives to_start/to_end from
// outstanding requests and, on timeout, returns one error response per pending request.
module npuarc_to_ctrl
  import npuarc_to_pkg::*;
#(
  parameter int OST_WIDTH       = OST_WIDTH_DEF,
  parameter bit RST_ON_PROGRESS = 1'b1,
  parameter int ERR_CNT_WIDTH   = ERR_CNT_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_a,
  input  logic                     clk_en,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     rsp_valid,
  output logic                     err_rsp_valid,
  input  logic                     err_rsp_ready,
  input  logic                     to_flag,
  output logic                     to_start,
  output logic                     to_end,
  output logic                     to_irq,
  input  logic                     irq_clr,
  output logic [OST_WIDTH-1:0]     ost_cnt,
  output logic [ERR_CNT_WIDTH-1:0] to_err_cnt
);

  state_t               state;
  state_t               state_nxt;
  logic                 full;
  logic                 acc;
  logic                 rsp;
  logic                 eh;
  logic                 abort_entry;
  logic [OST_WIDTH-1:0] ost_nxt;

  assign req_ready = ((state == ST_IDLE) || (state == ST_ARMED)) && !full;
  assign acc       = req_valid & req_ready & clk_en;
  assign rsp       = rsp_valid & clk_en;
  assign eh        = err_rsp_valid & err_rsp_ready & clk_en;

  npuarc_to_ost_cnt #(
    .WIDTH (OST_WIDTH)
  ) u_ost_cnt (
    .clk     (clk),
    .rst_a   (rst_a),
    .clk_en  (clk_en),
    .inc     (acc),
    .dec_a   (rsp),
    .dec_b   (eh),
    .cnt     (ost_cnt),
    .cnt_nxt (ost_nxt),
    .full    (full)
  );

  always_comb begin
    state_nxt = state;
    if (clk_en) begin
      case (state)
        ST_IDLE:
          if (ost_nxt != '0) state_nxt = ST_ARMED;
        ST_ARMED:
          if (to_flag)                     state_nxt = ST_ABORT;
          else if (ost_nxt == '0)          state_nxt = ST_END;
          else if (rsp && RST_ON_PROGRESS) state_nxt = ST_END;
        ST_END:
          if (to_flag)            state_nxt = ST_ABORT;
          else if (ost_nxt != '0) state_nxt = ST_ARMED;
          else                    state_nxt = ST_IDLE;
        ST_ABORT:
          if (ost_nxt == '0) state_nxt = ST_CLEAR;
        ST_CLEAR:
          if (!to_flag) state_nxt = ST_IDLE;
        default:
          state_nxt = ST_IDLE;
      endcase
    end
  end

  assign abort_entry = clk_en && (state != ST_ABORT) && (state_nxt == ST_ABORT);

  // Monitor levels are registered from the next state so they never glitch or overlap.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state         <= ST_IDLE;
      to_start      <= 1'b0;
      to_end        <= 1'b0;
      err_rsp_valid <= 1'b0;
    end else if (clk_en) begin
      state         <= state_nxt;
      to_start      <= (state_nxt == ST_ARMED) || (state_nxt == ST_ABORT);
      to_end        <= (state_nxt == ST_END) || (state_nxt == ST_CLEAR);
      err_rsp_valid <= (state_nxt == ST_ABORT) && (ost_nxt != '0);
    end
  end

  // A fresh abort outranks a coincident irq_clr so no timeout event is lost.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      to_irq     <= 1'b0;
      to_err_cnt <= '0;
    end else if (clk_en) begin
      if (abort_entry)
        to_irq <= 1'b1;
      else if (irq_clr)
        to_irq <= 1'b0;
      if (abort_entry && (to_err_cnt != '1))
        to_err_cnt <= to_err_cnt + ERR_CNT_WIDTH'(1);
    end
  end

endmodule
